// File: rtl/alu_core_if.sv
// -----------------------------------------------------------------------------
// alu_core_if : operand/result bundle for the VeriRISC ALU.
//
// Signals:
//   in_valid    operands and opcode are valid this cycle (master -> slave)
//   opcode      3-bit operation select                  (master -> slave)
//   in_a        accumulator operand                     (master -> slave)
//   in_b        second (memory/data) operand            (master -> slave)
//   out_valid   result registers hold a new result      (slave -> master)
//   a_is_zero   registered flag: captured in_a was zero (slave -> master)
//   alu_out     registered result                       (slave -> master)
//   carry_out   carry of ADD, 0 otherwise               (slave -> master, ALU_FLAGS_EN only)
//   out_is_zero registered result equals zero           (slave -> master, ALU_FLAGS_EN only)
//
// Build option: define ALU_FLAGS_EN to add carry_out and out_is_zero.
// Modports: master (the controller/datapath side) and slave (the ALU).
// -----------------------------------------------------------------------------
interface alu_core_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid;
    logic [2:0]            opcode;
    logic [DATA_WIDTH-1:0] in_a;
    logic [DATA_WIDTH-1:0] in_b;
    logic                  out_valid;
    logic                  a_is_zero;
    logic [DATA_WIDTH-1:0] alu_out;
`ifdef ALU_FLAGS_EN
    logic                  carry_out;
    logic                  out_is_zero;
`endif

`ifdef ALU_FLAGS_EN
    modport master (
        output in_valid, opcode, in_a, in_b,
        input  out_valid, a_is_zero, alu_out, carry_out, out_is_zero
    );

    modport slave (
        input  in_valid, opcode, in_a, in_b,
        output out_valid, a_is_zero, alu_out, carry_out, out_is_zero
    );
`else
    modport master (
        output in_valid, opcode, in_a, in_b,
        input  out_valid, a_is_zero, alu_out
    );

    modport slave (
        input  in_valid, opcode, in_a, in_b,
        output out_valid, a_is_zero, alu_out
    );
`endif
endinterface : alu_core_if

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core : registered arithmetic/logic unit for the VeriRISC datapath.
//
// One operation per cycle, one cycle of latency, no backpressure. Inputs
// sampled on a rising clk with in_valid=1 appear on the outputs right after
// that edge with out_valid=1. With in_valid=0 the result registers hold and
// out_valid drops.
//
// Ports:
//   clk   system clock, all state updates on the rising edge
//   rst   synchronous active-high reset (clears results and out_valid)
//   bus   alu_core_if.slave : in_valid, opcode, in_a, in_b in;
//                             out_valid, a_is_zero, alu_out out
//                             (+ carry_out, out_is_zero with ALU_FLAGS_EN)
//
// Parameters:
//   DATA_WIDTH  operand/result width, 2..64 (must match the interface)
//
// Build option: ALU_FLAGS_EN adds the registered carry_out/out_is_zero flags.
//
// Opcodes: 0,1,6,7 pass in_a; 2 add (wraps); 3 and; 4 xor; 5 pass in_b.
// a_is_zero reflects only in_a and is what the controller uses for
// skip-on-zero, so it must not depend on the opcode.
// -----------------------------------------------------------------------------
module alu_core #(
    parameter int DATA_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    alu_core_if.slave  bus
);

    typedef enum logic [2:0] {
        OP_PASS0 = 3'd0,
        OP_PASS1 = 3'd1,
        OP_ADD   = 3'd2,
        OP_AND   = 3'd3,
        OP_XOR   = 3'd4,
        OP_PASSB = 3'd5,
        OP_PASS6 = 3'd6,
        OP_PASS7 = 3'd7
    } opcode_e;

    // Reduction-based zero detect, shared by both zero flags.
    function automatic logic is_zero(input logic [DATA_WIDTH-1:0] value);
        is_zero = ~(|value);
    endfunction

    opcode_e               opcode_s;
    logic [DATA_WIDTH:0]   sum_s;
    logic [DATA_WIDTH-1:0] result_s;
    logic                  carry_s;
    logic                  a_zero_s;

    logic                  out_valid_r;
    logic                  a_is_zero_r;
    logic [DATA_WIDTH-1:0] alu_out_r;
`ifdef ALU_FLAGS_EN
    logic                  carry_out_r;
    logic                  out_is_zero_r;
`endif

    assign opcode_s = opcode_e'(bus.opcode);

    // Combinational result selection and flag generation for the current operands.
    always_comb begin
        // One bit wider than the operands so the ADD carry is available.
        sum_s    = {1'b0, bus.in_a} + {1'b0, bus.in_b};
        result_s = bus.in_a;
        carry_s  = 1'b0;
        a_zero_s = is_zero(bus.in_a);

        case (opcode_s)
            OP_PASS0: result_s = bus.in_a;
            OP_PASS1: result_s = bus.in_a;
            OP_ADD:   result_s = sum_s[DATA_WIDTH-1:0];
            OP_AND:   result_s = bus.in_a & bus.in_b;
            OP_XOR:   result_s = bus.in_a ^ bus.in_b;
            OP_PASSB: result_s = bus.in_b;
            OP_PASS6: result_s = bus.in_a;
            OP_PASS7: result_s = bus.in_a;
            default:  result_s = bus.in_a;
        endcase

        // Carry is only meaningful for ADD; every other opcode reports 0.
        if (opcode_s == OP_ADD) begin
            carry_s = sum_s[DATA_WIDTH];
        end else begin
            carry_s = 1'b0;
        end
    end

    // Output registers: reset wins, valid captures, otherwise hold results.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r   <= 1'b0;
            a_is_zero_r   <= 1'b0;
            alu_out_r     <= {DATA_WIDTH{1'b0}};
`ifdef ALU_FLAGS_EN
            carry_out_r   <= 1'b0;
            out_is_zero_r <= 1'b0;
`endif
        end else if (bus.in_valid) begin
            out_valid_r   <= 1'b1;
            a_is_zero_r   <= a_zero_s;
            alu_out_r     <= result_s;
`ifdef ALU_FLAGS_EN
            carry_out_r   <= carry_s;
            out_is_zero_r <= is_zero(result_s);
`endif
        end else begin
            // Bubble: results stay visible, only the valid strobe drops.
            out_valid_r   <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.a_is_zero = a_is_zero_r;
    assign bus.alu_out   = alu_out_r;
`ifdef ALU_FLAGS_EN
    assign bus.carry_out   = carry_out_r;
    assign bus.out_is_zero = out_is_zero_r;
`else
    // carry_s is only consumed when the flag outputs exist.
    logic unused_s;
    assign unused_s = carry_s;
`endif

endmodule : alu_core

// File: tb/tb_alu_core.sv
// -----------------------------------------------------------------------------
// tb_alu_core : directed self-checking bench for alu_core (DATA_WIDTH = 8).
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge that registered them.
// -----------------------------------------------------------------------------
module tb_alu_core;

    localparam int DW = 8;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    alu_core_if #(.DATA_WIDTH(DW)) bus ();

    alu_core #(.DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard bound on run time.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, required finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Drive one cycle of inputs, let one rising edge pass, sample.
    task automatic step(input logic r, input logic v, input logic [2:0] op,
                        input logic [DW-1:0] a, input logic [DW-1:0] b);
        @(negedge clk);
        rst          = r;
        bus.in_valid = v;
        bus.opcode   = op;
        bus.in_a     = a;
        bus.in_b     = b;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [DW-1:0] o,
                              input logic z, input logic c, input logic oz);
        chk({tag, ".valid"}, 64'(bus.out_valid), 64'(v));
        chk({tag, ".out"},   64'(bus.alu_out),   64'(o));
        chk({tag, ".azero"}, 64'(bus.a_is_zero), 64'(z));
`ifdef ALU_FLAGS_EN
        chk({tag, ".carry"}, 64'(bus.carry_out),   64'(c));
        chk({tag, ".ozero"}, 64'(bus.out_is_zero), 64'(oz));
`else
        if (c === 1'bx || oz === 1'bx) $display("note: flag expectation unknown for %s", tag);
`endif
    endtask

    logic [7:0] sweep_exp [8];

    initial begin
        n_total = 0;
        n_pass  = 0;
        sweep_exp[0] = 8'h42; sweep_exp[1] = 8'h42; sweep_exp[2] = 8'hC8;
        sweep_exp[3] = 8'h02; sweep_exp[4] = 8'hC4; sweep_exp[5] = 8'h86;
        sweep_exp[6] = 8'h42; sweep_exp[7] = 8'h42;

        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.opcode   = 3'd2;
        bus.in_a     = 8'h55;
        bus.in_b     = 8'h33;

        // Reset held two cycles with valid inputs present.
        step(1'b1, 1'b1, 3'd2, 8'h55, 8'h33);
        expect_out("rst0", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 3'd3, 8'h00, 8'hFF);
        expect_out("rst1", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Idle after reset.
        step(1'b0, 1'b0, 3'd5, 8'h11, 8'h22);
        expect_out("idle0", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 3'd2, 8'hFF, 8'hFF);
        expect_out("idle1", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Opcode sweep: 0x42 op 0x86 (ADD 0xC8, no carry).
        for (int op = 0; op < 8; op++) begin
            step(1'b0, 1'b1, 3'(op), 8'h42, 8'h86);
            expect_out($sformatf("sweep_op%0d", op), 1'b1, sweep_exp[op], 1'b0, 1'b0, 1'b0);
        end

        // Zero flag follows in_a only.
        step(1'b0, 1'b1, 3'd7, 8'h00, 8'h86);
        expect_out("zero_op7", 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 3'd5, 8'h00, 8'h86);
        expect_out("zero_op5", 1'b1, 8'h86, 1'b1, 1'b0, 1'b0);
        // Flags hold through a bubble even when in_a changes.
        step(1'b0, 1'b0, 3'd0, 8'h05, 8'h00);
        expect_out("zero_hold", 1'b0, 8'h86, 1'b1, 1'b0, 1'b0);

        // Wrap-around.
        step(1'b0, 1'b1, 3'd2, 8'hFF, 8'h01);
        expect_out("wrap", 1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
        // Carry/zero flags hold through a bubble.
        step(1'b0, 1'b0, 3'd3, 8'h00, 8'h00);
        expect_out("wrap_hold", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        // Hold and bubbles.
        step(1'b0, 1'b1, 3'd2, 8'h10, 8'h20);
        expect_out("hold_add", 1'b1, 8'h30, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 3'd3, 8'hFF, 8'hFF);
        expect_out("hold_b0", 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 3'd4, 8'h00, 8'h5A);
        expect_out("hold_b1", 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);

        // Reset mid-stream discards the pending XOR.
        step(1'b0, 1'b1, 3'd4, 8'h0F, 8'hF0);
        expect_out("xor", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 3'd4, 8'h33, 8'h11);
        expect_out("mid_rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 3'd4, 8'h0F, 8'hF0);
        expect_out("post_rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Back-to-back throughput after reset.
        step(1'b0, 1'b1, 3'd3, 8'hF0, 8'h3C);
        expect_out("b2b0", 1'b1, 8'h30, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'd2, 8'h80, 8'h80);
        expect_out("b2b1", 1'b1, 8'h00, 1'b0, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_alu_core

// File: doc/alu_core.md
Name: alu_core

Overview:
- Registered 8-bit-default arithmetic/logic unit for the VeriRISC datapath.
- Takes an accumulator operand (in_a), a memory/data operand (in_b) and a 3-bit opcode.
- Produces alu_out plus an accumulator-zero flag (a_is_zero) one clock later.
- The controller uses a_is_zero for skip-on-zero; alu_out feeds the accumulator.

Parameters:
- DATA_WIDTH, 8, operand and result width in bits (legal range 2 to 64).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and opcode are valid this cycle.
- opcode  input  3  operation select.
- in_a  input  DATA_WIDTH  accumulator operand.
- in_b  input  DATA_WIDTH  second operand.
- out_valid  output  1  alu_out and a_is_zero hold a new result.
- a_is_zero  output  1  registered flag: captured in_a was all zeros.
- alu_out  output  DATA_WIDTH  registered result.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset: on a rising clk with rst=1, alu_out=0, a_is_zero=0 and out_valid=0. rst has priority over in_valid. Reset mid-operation discards any pending result.
- Latency: exactly 1 cycle. Inputs sampled at edge N with in_valid=1 appear at outputs after edge N, with out_valid=1.
- Throughput: one operation per cycle. There is no backpressure.
- When in_valid=0 at an edge: out_valid goes to 0; alu_out and a_is_zero hold their previous values.
- Opcode decode:
  - 0 PASS0: in_a
  - 1 PASS1: in_a
  - 2 ADD: in_a + in_b, truncated to DATA_WIDTH (wraps modulo 2^DATA_WIDTH)
  - 3 AND: in_a & in_b
  - 4 XOR: in_a ^ in_b
  - 5 PASSB: in_b
  - 6 PASS6: in_a
  - 7 PASS7: in_a
- a_is_zero = 1 exactly when in_a == 0. It depends only on in_a and is independent of opcode and in_b.
- No X-propagation tolerance required. With in_valid=1 and known inputs, outputs must be fully known.
- Arithmetic is unsigned. No internal state beyond the output registers and the optional flag registers.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- When defined, two extra outputs are added, registered with the same timing, reset and hold rules as alu_out:
  - carry_out (1 bit): carry out of the ADD, i.e. bit DATA_WIDTH of the full-width sum. Forced to 0 for all non-ADD opcodes.
  - out_is_zero (1 bit): 1 when the computed result equals 0.
- When not defined, these ports and their registers do not exist. Core behaviour is identical in both builds.

Test Plan:
- Reset and idle: assert rst for 2 cycles with in_valid=1 and arbitrary inputs -> alu_out=0x00, a_is_zero=0, out_valid=0. Then deassert rst with in_valid=0 -> outputs hold 0, out_valid=0.
- Full opcode sweep, in_a=0x42, in_b=0x86, one opcode per cycle -> one cycle later alu_out is:
  - opcode 0, 1, 6, 7: 0x42
  - opcode 2 (ADD): 0xC8
  - opcode 3 (AND): 0x02
  - opcode 4 (XOR): 0xC4
  - opcode 5 (PASSB): 0x86
  - a_is_zero=0 and out_valid=1 throughout.
- Zero flag: opcode=7, in_a=0x00, in_b=0x86 -> alu_out=0x00, a_is_zero=1. Then opcode=5, in_a=0x00, in_b=0x86 -> alu_out=0x86, a_is_zero=1.
- Wrap-around: opcode=2, in_a=0xFF, in_b=0x01 -> alu_out=0x00, a_is_zero=0. With ALU_FLAGS_EN: carry_out=1, out_is_zero=1.
- Hold and bubbles: valid ADD 0x10+0x20, then in_valid=0 for 2 cycles with changing inputs -> alu_out stays 0x30, out_valid pulses 1 then 0, 0.
- Reset mid-stream: rst=1 on the cycle after a valid XOR -> next cycle alu_out=0x00, out_valid=0. The XOR result is never presented after reset.
